// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl
// Boot-time program loader. Assembles a little-endian byte stream into
// 32-bit words, writes them to the instruction memory, pads the rest of
// the memory with FILL_WORD and then releases the core from reset.

module imem_boot_ctrl #(
    parameter int          IM_WORDS  = 1024,
    parameter int          AW        = 10,
    parameter logic [31:0] FILL_WORD = 32'h00000013
) (
    input  logic          clk,
    input  logic          resetb,
    input  logic          start,
    input  logic [AW+2:0] byte_count,
    input  logic          rx_valid,
    input  logic [7:0]    rx_data,
    output logic          rx_ready,
    output logic          im_we,
    output logic [AW-1:0] im_waddr,
    output logic [31:0]   im_wdata,
    output logic          core_resetb,
    output logic          busy,
    output logic          done,
    output logic          overflow_err
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RECV    = 3'd1;
    localparam logic [2:0] ST_WRITE   = 3'd2;
    localparam logic [2:0] ST_FILL    = 3'd3;
    localparam logic [2:0] ST_RELEASE = 3'd4;
    localparam logic [2:0] ST_RUN     = 3'd5;

    // Whole memory in bytes; the byte counter is one bit wider than a
    // byte address so this value is representable.
    localparam logic [AW+2:0] MAX_BYTES = (AW+3)'(IM_WORDS * 4);
    localparam logic [AW-1:0] LAST_IDX  = AW'(IM_WORDS - 1);

    // Control state
    logic [2:0]    state_q,    state_d;
    logic [AW+2:0] count_q,    count_d;     // clamped number of bytes to load
    logic [AW+2:0] rcvd_q,     rcvd_d;      // bytes accepted so far
    logic [AW-1:0] word_idx_q, word_idx_d;  // word currently being built/filled
    logic [1:0]    lane_q,     lane_d;      // next byte lane in the word
    logic [31:0]   asm_q,      asm_d;       // word assembly register

    // Registered outputs
    logic          rx_ready_q,    rx_ready_d;
    logic          im_we_q,       im_we_d;
    logic [AW-1:0] im_waddr_q,    im_waddr_d;
    logic [31:0]   im_wdata_q,    im_wdata_d;
    logic          core_resetb_q, core_resetb_d;
    logic          busy_q,        busy_d;
    logic          done_q,        done_d;
    logic          ovf_q,         ovf_d;

    // Helpers
    logic [AW+2:0] count_clamped;
    logic          count_over;
    logic [AW+2:0] rcvd_inc;
    logic [AW-1:0] word_idx_inc;
    logic [31:0]   byte_shifted;
    logic          accept;

    // Request clamping, byte placement and handshake decode
    always_comb begin
        count_over    = (byte_count > MAX_BYTES);
        count_clamped = count_over ? MAX_BYTES : byte_count;
        rcvd_inc      = rcvd_q + 1'b1;
        word_idx_inc  = word_idx_q + 1'b1;
        byte_shifted  = {24'd0, rx_data} << {lane_q, 3'b000};
        accept        = rx_valid && rx_ready_q;
    end

    // Next-state and next-output logic; every output is a register, so
    // the values for the coming state are decided here on the transition.
    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        rcvd_d        = rcvd_q;
        word_idx_d    = word_idx_q;
        lane_d        = lane_q;
        asm_d         = asm_q;
        rx_ready_d    = 1'b0;
        im_we_d       = 1'b0;
        im_waddr_d    = im_waddr_q;
        im_wdata_d    = im_wdata_q;
        core_resetb_d = core_resetb_q;
        busy_d        = busy_q;
        done_d        = done_q;
        ovf_d         = ovf_q;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if (start) begin
                    count_d       = count_clamped;
                    ovf_d         = count_over;
                    rcvd_d        = '0;
                    word_idx_d    = '0;
                    lane_d        = 2'd0;
                    asm_d         = 32'd0;
                    busy_d        = 1'b1;
                    core_resetb_d = 1'b0;
                    done_d        = 1'b0;
                    if (count_clamped != '0) begin
                        state_d    = ST_RECV;
                        rx_ready_d = 1'b1;
                    end else begin
                        // Empty image: go straight to padding from word 0.
                        state_d    = ST_FILL;
                        im_we_d    = 1'b1;
                        im_waddr_d = '0;
                        im_wdata_d = FILL_WORD;
                    end
                end
            end

            ST_RECV: begin
                rx_ready_d = 1'b1;
                if (accept) begin
                    asm_d  = asm_q | byte_shifted;
                    rcvd_d = rcvd_inc;
                    lane_d = lane_q + 2'd1;
                    if ((lane_q == 2'd3) || (rcvd_inc == count_q)) begin
                        // Word complete (or stream exhausted): drop ready so
                        // nothing is taken while the word is written.
                        state_d    = ST_WRITE;
                        rx_ready_d = 1'b0;
                        im_we_d    = 1'b1;
                        im_waddr_d = word_idx_q;
                        im_wdata_d = asm_q | byte_shifted;
                    end
                end
            end

            ST_WRITE: begin
                asm_d  = 32'd0;
                lane_d = 2'd0;
                if (rcvd_q != count_q) begin
                    state_d    = ST_RECV;
                    rx_ready_d = 1'b1;
                    word_idx_d = word_idx_inc;
                end else if (word_idx_q != LAST_IDX) begin
                    state_d    = ST_FILL;
                    word_idx_d = word_idx_inc;
                    im_we_d    = 1'b1;
                    im_waddr_d = word_idx_inc;
                    im_wdata_d = FILL_WORD;
                end else begin
                    // Image covered the whole memory; no padding needed and
                    // the index is left in place rather than wrapping.
                    state_d = ST_RELEASE;
                    busy_d  = 1'b0;
                end
            end

            ST_FILL: begin
                // word_idx_q is the address being written this cycle.
                if (word_idx_q == LAST_IDX) begin
                    state_d = ST_RELEASE;
                    busy_d  = 1'b0;
                end else begin
                    word_idx_d = word_idx_inc;
                    im_we_d    = 1'b1;
                    im_waddr_d = word_idx_inc;
                    im_wdata_d = FILL_WORD;
                end
            end

            ST_RELEASE: begin
                // One idle cycle after the last write before the core runs.
                state_d       = ST_RUN;
                core_resetb_d = 1'b1;
                done_d        = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q       <= ST_IDLE;
            count_q       <= '0;
            rcvd_q        <= '0;
            word_idx_q    <= '0;
            lane_q        <= 2'd0;
            asm_q         <= 32'd0;
            rx_ready_q    <= 1'b0;
            im_we_q       <= 1'b0;
            im_waddr_q    <= '0;
            im_wdata_q    <= 32'd0;
            core_resetb_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            ovf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            rcvd_q        <= rcvd_d;
            word_idx_q    <= word_idx_d;
            lane_q        <= lane_d;
            asm_q         <= asm_d;
            rx_ready_q    <= rx_ready_d;
            im_we_q       <= im_we_d;
            im_waddr_q    <= im_waddr_d;
            im_wdata_q    <= im_wdata_d;
            core_resetb_q <= core_resetb_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            ovf_q         <= ovf_d;
        end
    end

    assign rx_ready     = rx_ready_q;
    assign im_we        = im_we_q;
    assign im_waddr     = im_waddr_q;
    assign im_wdata     = im_wdata_q;
    assign core_resetb  = core_resetb_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign overflow_err = ovf_q;

endmodule
